gate_bist_ctrl: RTL and testbench
=================================

Name: gate_bist_ctrl

Overview:
- Built-in self-test initiator for the two-input logic-gate unit (outputs AND, OR, NOT-a, XOR, XNOR, NAND).
- Drives a/b stimulus patterns into the gate unit, waits a programmable settle time, then samples the six gate outputs and compares them against internally computed expected values.
- Reports pass/fail, a saturating mismatch count, a sticky per-gate fail vector and the first failing pattern.
- Sits beside the gate unit as its test-side counterpart.

Parameters:
- NUM_PASSES, 1: number of full sweeps over the 4 patterns (>=1).
- SETTLE_CYCLES, 1: cycles between driving a pattern and sampling (>=0).
- ERR_CNT_W, 4: width of the mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin test; sampled only in IDLE.
- a_out  out  1  stimulus a to gate unit.
- b_out  out  1  stimulus b to gate unit.
- and_g, or_g, not_a_g, xor_g, xnor_g, nand_g  in  1 each  gate unit responses.
- busy  out  1  test in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  1 = last run had zero mismatches; held until next start.
- err_cnt  out  ERR_CNT_W  mismatching samples, saturating.
- fail_vec  out  6  sticky per-gate fail bits. Bit mapping: [0]and [1]or [2]not_a [3]xor [4]xnor [5]nand.
- first_fail_pat  out  2  {a,b} of first mismatching sample; 0 if none.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1, all outputs are 0 and the FSM is forced to IDLE. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE:
  - a_out=b_out=0.
  - start=1 -> DRIVE. On the same edge: clear err_cnt, fail_vec, first_fail_pat and pass; reset the pattern counter to 00 and the pass counter to 0.
- DRIVE (1 cycle):
  - {a_out,b_out} <= pattern; outputs are registered.
  - Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: stay exactly SETTLE_CYCLES cycles, then -> CHECK. Settle counter width is clog2(SETTLE_CYCLES+1).
- CHECK (1 cycle):
  - Expected values: and=a&b, or=a|b, not_a=~a, xor=a^b, xnor=~(a^b), nand=~(a&b), computed from a_out/b_out.
  - mismatch = expected XOR sampled (6 bits).
  - If any mismatch bit is set:
    - err_cnt += 1, saturating at 2^ERR_CNT_W-1.
    - fail_vec |= mismatch.
    - If this is the first failure of the run, latch first_fail_pat={a_out,b_out}.
  - err_cnt counts failing samples, not failing bits.
- Advance after CHECK:
  - Pattern order 00,01,10,11, wrapping to 00.
  - After pattern 11: increment the pass counter. If it reaches NUM_PASSES -> DONE, else -> DRIVE.
  - Otherwise -> DRIVE.
- DONE (1 cycle):
  - done=1 and busy=0; a_out=b_out=0.
  - pass <= (err_cnt==0); then -> IDLE.
  - start is ignored in DONE.
- busy is high in DRIVE, SETTLE and CHECK.
- Timing:
  - One pattern takes SETTLE_CYCLES+2 cycles.
  - busy stays high for 4*NUM_PASSES*(SETTLE_CYCLES+2) cycles, beginning the cycle after start is sampled.
  - done occurs in the cycle immediately after busy falls.
- start asserted while busy or in DONE: ignored, not queued.
- start held high continuously: a new run begins in the IDLE cycle following DONE.
- pass, err_cnt, fail_vec and first_fail_pat hold their values in IDLE until the next accepted start.

Optional Feature:
- Macro: GATE_BIST_STOP_ON_FAIL_EN.
- Defined: a CHECK with any mismatch updates the status outputs as normal, then goes directly to DONE, skipping remaining patterns and passes. err_cnt therefore ends at 0 or 1.
- Undefined: the full sweep always runs; behaviour is exactly as described above.

Test Plan:
- Defaults, golden gate model, 1-cycle start pulse -> busy high 12 cycles; done pulse on the next cycle; pass=1, err_cnt=0, fail_vec=6'b000000, first_fail_pat=2'b00.
- xor_g stuck at 0 -> mismatches on patterns 01 and 10 -> err_cnt=2, fail_vec=6'b001000, first_fail_pat=2'b01, pass=0.
- NUM_PASSES=3, nand_g stuck at 1 -> mismatch on pattern 11 in each pass -> err_cnt=3, fail_vec=6'b100000, first_fail_pat=2'b11, busy high 36 cycles.
- ERR_CNT_W=2, all six responses inverted -> err_cnt saturates at 3 (not 4), fail_vec=6'b111111, first_fail_pat=2'b00.
- SETTLE_CYCLES=0 -> busy high 8 cycles. Assert rst in busy cycle 5 -> all outputs 0 immediately, no done pulse. Pulse start during busy -> ignored, run length unchanged.
- With GATE_BIST_STOP_ON_FAIL_EN, xor_g stuck at 0 -> busy high 6 cycles (patterns 00 and 01), then done; err_cnt=1, fail_vec=6'b001000, first_fail_pat=2'b01.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_ctrl
// Purpose  : Built-in self-test initiator for the two-input logic-gate unit.
//            Sweeps the four {a,b} patterns NUM_PASSES times, waits
//            SETTLE_CYCLES after each drive, samples the six gate responses
//            and compares them with locally computed expected values.
// Ports    : clk, rst (async, active-high)
//            start            - begin a run (only looked at in IDLE)
//            a_out, b_out     - registered stimulus to the gate unit
//            and_g .. nand_g  - gate unit responses
//            busy             - high in DRIVE / SETTLE / CHECK
//            done             - one-cycle completion pulse
//            pass             - last run had no mismatches
//            err_cnt          - saturating count of mismatching samples
//            fail_vec         - sticky per-gate fail bits
//                               [0]and [1]or [2]not_a [3]xor [4]xnor [5]nand
//            first_fail_pat   - {a,b} of first mismatching sample
// Options  : GATE_BIST_STOP_ON_FAIL_EN - end the run at the first failing
//            CHECK instead of completing the sweep.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist_ctrl #(
  parameter int NUM_PASSES    = 1,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a_out,
  output logic                 b_out,
  input  logic                 and_g,
  input  logic                 or_g,
  input  logic                 not_a_g,
  input  logic                 xor_g,
  input  logic                 xnor_g,
  input  logic                 nand_g,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [5:0]           fail_vec,
  output logic [1:0]           first_fail_pat
);

  // Settle counter needs at least one bit even when settling is disabled.
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = $clog2(NUM_PASSES + 1);

  localparam logic [SW-1:0] C_SETTLE_LAST =
    SW'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [PW-1:0]        C_PASS_LAST = PW'(NUM_PASSES - 1);
  localparam logic [ERR_CNT_W-1:0] C_ERR_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_pat;
  logic [PW-1:0]   r_pass_cnt;
  logic [SW-1:0]   r_settle_cnt;

  logic [5:0]      w_exp;
  logic [5:0]      w_resp;
  logic [5:0]      w_mismatch;
  logic            w_fail;
  logic            w_last_pat;
  logic            w_last_pass;

  // Expected responses use the stimulus currently presented to the gate unit.
  assign w_exp = {~(a_out & b_out), ~(a_out ^ b_out), a_out ^ b_out,
                  ~a_out, a_out | b_out, a_out & b_out};
  assign w_resp      = {nand_g, xnor_g, xor_g, not_a_g, or_g, and_g};
  assign w_mismatch  = w_exp ^ w_resp;
  assign w_fail      = |w_mismatch;
  assign w_last_pat  = (r_pat == 2'b11);
  assign w_last_pass = (r_pass_cnt == C_PASS_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Next-state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (SETTLE_CYCLES > 0) w_next = S_SETTLE;
        else                   w_next = S_CHECK;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (r_settle_cnt == C_SETTLE_LAST) w_next = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (w_last_pat && w_last_pass) w_next = S_DONE;
        else                           w_next = S_DRIVE;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        if (w_fail) w_next = S_DONE;
`endif
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Stimulus, counters and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      fail_vec       <= '0;
      first_fail_pat <= '0;
      r_pat          <= '0;
      r_pass_cnt     <= '0;
      r_settle_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pat          <= '0;
            r_pass_cnt     <= '0;
            err_cnt        <= '0;
            fail_vec       <= '0;
            first_fail_pat <= '0;
            pass           <= 1'b0;
          end
        end
        S_DRIVE: begin
          {a_out, b_out} <= r_pat;
          r_settle_cnt   <= '0;
        end
        S_SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 1'b1;
        end
        S_CHECK: begin
          if (w_fail) begin
            if (err_cnt != C_ERR_MAX) err_cnt <= err_cnt + 1'b1;
            fail_vec <= fail_vec | w_mismatch;
            // err_cnt never returns to zero within a run, so zero marks
            // "no failure seen yet".
            if (err_cnt == '0) first_fail_pat <= {a_out, b_out};
          end
          r_pat <= r_pat + 2'd1;
          if (w_last_pat) r_pass_cnt <= r_pass_cnt + 1'b1;
          // Park the stimulus low for the DONE cycle.
          if (w_next == S_DONE) {a_out, b_out} <= 2'b00;
        end
        S_DONE: begin
          pass           <= (err_cnt == '0);
          {a_out, b_out} <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist_ctrl
// Purpose  : Self-checking bench for gate_bist_ctrl. Four instances cover the
//            default build, NUM_PASSES=3, ERR_CNT_W=2 and SETTLE_CYCLES=0,
//            each driven by a behavioural gate unit with injectable faults.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bist_ctrl;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam int C_XOR_LEN = 6,  C_XOR_ERR = 1;
  localparam int C_NAND_LEN = 12, C_NAND_ERR = 1;
  localparam int C_INV_LEN = 3,  C_INV_ERR = 1;
`else
  localparam int C_XOR_LEN = 12, C_XOR_ERR = 2;
  localparam int C_NAND_LEN = 36, C_NAND_ERR = 3;
  localparam int C_INV_LEN = 12, C_INV_ERR = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [3:0] start;
  logic [3:0] a_o, b_o, busy_o, done_o, pass_o;
  logic [3:0] err0, err1, err3;
  logic [1:0] err2;
  logic [3:0][5:0] fv;
  logic [3:0][1:0] ffp;

  // Fault injection: invert mask, stuck mask and stuck value per instance.
  logic [3:0][5:0] inv, msk, val;
  logic [3:0][5:0] resp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] golden(input logic a, input logic b);
    return {~(a & b), ~(a ^ b), a ^ b, ~a, a | b, a & b};
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++)
      resp[k] = ((golden(a_o[k], b_o[k]) ^ inv[k]) & ~msk[k]) | (val[k] & msk[k]);
  end

  gate_bist_ctrl u0 (
    .clk(clk), .rst(rst), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]),
    .and_g(resp[0][0]), .or_g(resp[0][1]), .not_a_g(resp[0][2]),
    .xor_g(resp[0][3]), .xnor_g(resp[0][4]), .nand_g(resp[0][5]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_cnt(err0),
    .fail_vec(fv[0]), .first_fail_pat(ffp[0])
  );

  gate_bist_ctrl #(.NUM_PASSES(3)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]),
    .and_g(resp[1][0]), .or_g(resp[1][1]), .not_a_g(resp[1][2]),
    .xor_g(resp[1][3]), .xnor_g(resp[1][4]), .nand_g(resp[1][5]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_cnt(err1),
    .fail_vec(fv[1]), .first_fail_pat(ffp[1])
  );

  gate_bist_ctrl #(.ERR_CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .a_out(a_o[2]), .b_out(b_o[2]),
    .and_g(resp[2][0]), .or_g(resp[2][1]), .not_a_g(resp[2][2]),
    .xor_g(resp[2][3]), .xnor_g(resp[2][4]), .nand_g(resp[2][5]),
    .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_cnt(err2),
    .fail_vec(fv[2]), .first_fail_pat(ffp[2])
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(0)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .a_out(a_o[3]), .b_out(b_o[3]),
    .and_g(resp[3][0]), .or_g(resp[3][1]), .not_a_g(resp[3][2]),
    .xor_g(resp[3][3]), .xnor_g(resp[3][4]), .nand_g(resp[3][5]),
    .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]), .err_cnt(err3),
    .fail_vec(fv[3]), .first_fail_pat(ffp[3])
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int errv(input int k);
    case (k)
      0:       return int'(err0);
      1:       return int'(err1);
      2:       return int'(err2);
      default: return int'(err3);
    endcase
  endfunction

  // Pulse start for one cycle, measure busy length, check the done pulse.
  // A non-zero glitch_at re-pulses start in that busy cycle.
  task automatic run(input int k, input string tag, input int exp_len,
                     input int glitch_at);
    int len;
    len = 0;
    @(negedge clk) start[k] = 1'b1;
    @(negedge clk) start[k] = 1'b0;
    while (busy_o[k] && len < 200) begin
      len++;
      start[k] = (len == glitch_at);
      @(negedge clk);
    end
    start[k] = 1'b0;
    check({tag, "_busy_len"}, len, exp_len);
    check({tag, "_done"}, done_o[k], 1);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy_o[k], done_o[k]}, 0);
  endtask

  task automatic results(input int k, input string tag, input int p,
                         input int e, input int f, input int ff);
    check({tag, "_pass"}, pass_o[k], p);
    check({tag, "_err_cnt"}, errv(k), e);
    check({tag, "_fail_vec"}, fv[k], f);
    check({tag, "_first_fail"}, ffp[k], ff);
  endtask

  initial begin
    int dones;
    rst   = 1'b1;
    start = '0;
    inv   = '0;
    msk   = '0;
    val   = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], err0, fv[0], ffp[0]}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Golden run on default configuration
    run(0, "golden", 12, 0);
    results(0, "golden", 1, 0, 6'b000000, 2'b00);
    repeat (3) @(negedge clk);
    check("golden_pass_held", pass_o[0], 1);

    // xor_g stuck at 0
    msk[0] = 6'b001000;
    run(0, "xor_s0", C_XOR_LEN, 0);
    results(0, "xor_s0", 0, C_XOR_ERR, 6'b001000, 2'b01);

    // NUM_PASSES=3, nand_g stuck at 1
    msk[1] = 6'b100000;
    val[1] = 6'b100000;
    run(1, "nand_s1", C_NAND_LEN, 0);
    results(1, "nand_s1", 0, C_NAND_ERR, 6'b100000, 2'b11);

    // ERR_CNT_W=2, every response inverted
    inv[2] = 6'b111111;
    run(2, "inv_all", C_INV_LEN, 0);
    results(2, "inv_all", 0, C_INV_ERR, 6'b111111, 2'b00);

    // SETTLE_CYCLES=0 golden run
    run(3, "nosettle", 8, 0);
    results(3, "nosettle", 1, 0, 6'b000000, 2'b00);

    // Reset in busy cycle 5 aborts with all outputs low and no done
    @(negedge clk) start[3] = 1'b1;
    @(negedge clk) start[3] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy_o[3], 1);
    rst = 1'b1;
    #1;
    check("abort_outputs",
          {a_o[3], b_o[3], busy_o[3], done_o[3], pass_o[3], err3, fv[3], ffp[3]}, 0);
    @(negedge clk) rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o[3] || busy_o[3]) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);

    // start re-pulsed mid-run is ignored
    run(3, "start_ignored", 8, 3);
    repeat (3) @(negedge clk);
    check("start_not_queued", busy_o[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
